// File: rtl/aurora_tx_pkg.sv
// aurora_tx_pkg: shared types, defaults and checksum helper for the Aurora TX framer
package aurora_tx_pkg;

    typedef enum logic [2:0] {IDLE, HDR, PAY, TRL, FLUSH} state_t;

    localparam logic [15:0] HDR_MAGIC_DEF = 16'hBC5A;
    localparam logic [15:0] TRL_MAGIC_DEF = 16'hE7D3;
    localparam int FLAG_TRUNC = 0;

    // Folds one payload beat to 16 bits; bytes with keep=0 contribute zero.
    function automatic logic [15:0] fold16(input logic [63:0] data, input logic [7:0] keep);
        logic [63:0] m;
        for (int i = 0; i < 8; i++) m[i*8 +: 8] = keep[i] ? data[i*8 +: 8] : 8'h00;
        return m[63:48] ^ m[47:32] ^ m[31:16] ^ m[15:0];
    endfunction

endpackage

// File: rtl/aurora_tx_outreg.sv
// aurora_tx_outreg: single-entry AXI-stream output register feeding the Aurora TX port
module aurora_tx_outreg (
    input  logic        SysClk,
    input  logic        Rst_n,
    input  logic        drop,
    input  logic        load,
    input  logic [63:0] ld_data,
    input  logic [7:0]  ld_keep,
    input  logic        ld_last,
    input  logic        m_tready,
    output logic [63:0] m_tdata,
    output logic [7:0]  m_tkeep,
    output logic        m_tlast,
    output logic        m_tvalid,
    output logic        load_ok
);

    assign load_ok = !m_tvalid | m_tready;

    // Hold a word until handshake; channel loss discards it outright.
    always_ff @(posedge SysClk) begin
        if (!Rst_n) begin
            m_tdata  <= '0;
            m_tkeep  <= '0;
            m_tlast  <= 1'b0;
            m_tvalid <= 1'b0;
        end else if (drop) begin
            m_tvalid <= 1'b0;
        end else if (load) begin
            m_tdata  <= ld_data;
            m_tkeep  <= ld_keep;
            m_tlast  <= ld_last;
            m_tvalid <= 1'b1;
        end else if (m_tready) begin
            m_tvalid <= 1'b0;
        end
    end

endmodule

// File: rtl/aurora_tx_framer.sv
// aurora_tx_framer: wraps AXI-stream packets into header/payload/trailer Aurora frames
module aurora_tx_framer
    import aurora_tx_pkg::*;
#(
    parameter int          MAX_WORDS = 256,
    parameter logic [15:0] HDR_MAGIC = HDR_MAGIC_DEF,
    parameter logic [15:0] TRL_MAGIC = TRL_MAGIC_DEF
) (
    input  logic        SysClk,
    input  logic        Rst_n,
    input  logic        channel_up,
    input  logic [63:0] s_data,
    input  logic [7:0]  s_keep,
    input  logic        s_last,
    input  logic        s_valid,
    output logic        s_ready,
    output logic [63:0] m_tdata,
    output logic [7:0]  m_tkeep,
    output logic        m_tlast,
    output logic        m_tvalid,
    input  logic        m_tready,
    output logic [31:0] frame_cnt,
    output logic [15:0] abort_cnt,
    output logic        trunc_pulse
);

    state_t      state;
    logic [15:0] seq;
    logic [15:0] word_cnt;
    logic [15:0] xsum;
    logic        trunc;
    logic        trl_loaded;
    logic        load_ok;
    logic        load;
    logic        acc;
    logic        trl_hs;
    logic        lost;
    logic        hit;
    logic [63:0] ld_data;
    logic [7:0]  ld_keep;
    logic [7:0]  flags;

    // Input acceptance, loss detection and the word offered to the output register.
    always_comb begin
        flags = '0;
        flags[FLAG_TRUNC] = trunc;
        s_ready = state == PAY ? channel_up & load_ok : state == FLUSH;
        acc = s_valid & s_ready;
        trl_hs = state == TRL & trl_loaded & m_tvalid & m_tready;
        lost = !channel_up & (state == HDR | state == PAY | state == TRL) & !trl_hs;
        hit = {1'b0, word_cnt} + 17'd1 == 17'(MAX_WORDS);
        load = state == IDLE ? s_valid & channel_up & load_ok :
               state == PAY  ? acc :
               state == TRL  ? !trl_loaded & channel_up & load_ok : 1'b0;
        ld_data = state == IDLE ? {HDR_MAGIC, seq, 32'h0} :
                  state == PAY  ? s_data : {TRL_MAGIC, flags, 8'h00, word_cnt, xsum};
        ld_keep = state == PAY ? s_keep : 8'hFF;
    end

    aurora_tx_outreg u_outreg (
        .SysClk   (SysClk),
        .Rst_n    (Rst_n),
        .drop     (lost),
        .load     (load),
        .ld_data  (ld_data),
        .ld_keep  (ld_keep),
        .ld_last  (state == TRL),
        .m_tready (m_tready),
        .m_tdata  (m_tdata),
        .m_tkeep  (m_tkeep),
        .m_tlast  (m_tlast),
        .m_tvalid (m_tvalid),
        .load_ok  (load_ok)
    );

    // Frame sequencing; a truncated frame doubles as the "flush the rest" marker.
    always_ff @(posedge SysClk) begin
        if (!Rst_n) begin
            state       <= IDLE;
            seq         <= '0;
            word_cnt    <= '0;
            xsum        <= '0;
            trunc       <= 1'b0;
            trl_loaded  <= 1'b0;
            frame_cnt   <= '0;
            abort_cnt   <= '0;
            trunc_pulse <= 1'b0;
        end else begin
            trunc_pulse <= 1'b0;
            if (lost) begin
                abort_cnt <= abort_cnt == 16'hFFFF ? abort_cnt : abort_cnt + 16'd1;
                state     <= state == TRL ? IDLE : FLUSH;
            end else begin
                case (state)
                    IDLE: if (load) begin
                        state      <= HDR;
                        word_cnt   <= '0;
                        xsum       <= '0;
                        trunc      <= 1'b0;
                        trl_loaded <= 1'b0;
                    end
                    HDR: if (m_tvalid & m_tready) state <= PAY;
                    PAY: if (acc) begin
                        word_cnt <= word_cnt + 16'd1;
                        xsum     <= xsum ^ fold16(s_data, s_keep);
                        if (s_last | hit) begin
                            state <= TRL;
                            trunc <= !s_last;
                        end
                    end
                    TRL: if (trl_hs) begin
                        frame_cnt   <= frame_cnt + 32'd1;
                        seq         <= seq + 16'd1;
                        trunc_pulse <= trunc;
                        state       <= trunc ? FLUSH : IDLE;
                    end else if (load) begin
                        trl_loaded <= 1'b1;
                    end
                    FLUSH: if (acc & s_last) state <= IDLE;
                    default: state <= IDLE;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_aurora_tx_framer.sv
// tb_aurora_tx_framer: randomized stream bench with a packet-level frame model
module tb_aurora_tx_framer;

    localparam int MAXW = 4;

    logic        SysClk = 1'b0;
    logic        Rst_n = 1'b0;
    logic        channel_up = 1'b0;
    logic [63:0] s_data = '0;
    logic [7:0]  s_keep = '0;
    logic        s_last = 1'b0;
    logic        s_valid = 1'b0;
    logic        s_ready;
    logic [63:0] m_tdata;
    logic [7:0]  m_tkeep;
    logic        m_tlast;
    logic        m_tvalid;
    logic        m_tready = 1'b0;
    logic [31:0] frame_cnt;
    logic [15:0] abort_cnt;
    logic        trunc_pulse;

    aurora_tx_framer #(.MAX_WORDS(MAXW)) dut (
        .SysClk      (SysClk),
        .Rst_n       (Rst_n),
        .channel_up  (channel_up),
        .s_data      (s_data),
        .s_keep      (s_keep),
        .s_last      (s_last),
        .s_valid     (s_valid),
        .s_ready     (s_ready),
        .m_tdata     (m_tdata),
        .m_tkeep     (m_tkeep),
        .m_tlast     (m_tlast),
        .m_tvalid    (m_tvalid),
        .m_tready    (m_tready),
        .frame_cnt   (frame_cnt),
        .abort_cnt   (abort_cnt),
        .trunc_pulse (trunc_pulse)
    );

    always #5 SysClk = ~SysClk;

    typedef struct {logic [63:0] d; logic [7:0] k; logic l;} beat_t;
    typedef struct {logic [63:0] d; logic [7:0] k; logic l; int kind;} word_t;

    beat_t       src_q[$];
    beat_t       pkt[$];
    word_t       exp_q[$];
    int          checks = 0;
    int          errors = 0;
    int          hs_cnt = 0;
    int          trunc_seen = 0;
    int          m_trunc = 0;
    int          m_frames = 0;
    int          m_aborts = 0;
    logic [15:0] m_seq = '0;
    int          gap = 0;
    int          rmode = 0;
    logic [63:0] last_hdr = '0;
    logic [63:0] last_trl = '0;
    logic [63:0] mt;
    logic        prev_v = 1'b0;
    logic        prev_r = 1'b0;
    logic        prev_cu = 1'b0;
    logic        prev_l = 1'b0;
    logic [7:0]  prev_k = '0;
    logic [63:0] prev_d = '0;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h want %h", nm, act, exp);
        end
    endtask

    // One clock: sample handshakes at negedge, drive new inputs just after posedge.
    task automatic step();
        logic a;
        @(negedge SysClk);
        a = s_valid & s_ready;
        @(posedge SysClk);
        #1;
        if (a) src_q.delete(0);
        if (!s_valid || a) begin
            if (src_q.size() > 0 && $urandom_range(3) >= gap) begin
                s_valid = 1'b1;
                s_data  = src_q[0].d;
                s_keep  = src_q[0].k;
                s_last  = src_q[0].l;
            end else begin
                s_valid = 1'b0;
            end
        end
        m_tready = rmode == 0 ? 1'b1 : rmode == 1 ? !m_tready :
                   rmode == 2 ? 1'($urandom_range(1)) : 1'b0;
    endtask

    task automatic mk(input int n);
        pkt.delete();
        for (int i = 0; i < n; i++) begin
            beat_t b;
            b.d = {$urandom(), $urandom()};
            b.k = i == n - 1 ? 8'($urandom_range(1, 255)) : 8'hFF;
            b.l = i == n - 1;
            pkt.push_back(b);
        end
    endtask

    task automatic mk_a();
        pkt.delete();
        pkt.push_back('{64'h0001_0002_0004_0008, 8'hFF, 1'b0});
        pkt.push_back('{64'h0010_0020_0040_0080, 8'hFF, 1'b0});
        pkt.push_back('{64'h0100_0200_0400_0800, 8'hFF, 1'b0});
        pkt.push_back('{64'hFFFF_FFFF_1000_2000, 8'h0F, 1'b1});
    endtask

    // Expected frame straight from the framing rules: header, first MAXW beats, trailer.
    task automatic send_pkt(output logic [63:0] trl);
        int          n_out;
        bit          tr;
        logic [15:0] x;
        n_out = pkt.size() < MAXW ? pkt.size() : MAXW;
        tr = pkt.size() > MAXW;
        x = '0;
        exp_q.push_back('{{16'hBC5A, m_seq, 32'h0}, 8'hFF, 1'b0, 0});
        for (int i = 0; i < n_out; i++) begin
            exp_q.push_back('{pkt[i].d, pkt[i].k, 1'b0, 1});
            for (int j = 0; j < 8; j++)
                if (pkt[i].k[j]) x[(j % 2) * 8 +: 8] = x[(j % 2) * 8 +: 8] ^ pkt[i].d[j*8 +: 8];
        end
        trl = {16'hE7D3, 7'h0, tr, 8'h00, 16'(n_out), x};
        exp_q.push_back('{trl, 8'hFF, 1'b1, 2});
        m_seq++;
        m_frames++;
        m_trunc += int'(tr);
        foreach (pkt[i]) src_q.push_back(pkt[i]);
    endtask

    task automatic drain(input string nm);
        int n;
        n = 0;
        while (n < 2000 && (src_q.size() != 0 || exp_q.size() != 0 || m_tvalid)) begin
            step();
            n++;
        end
        checks++;
        if (n >= 2000) begin
            errors++;
            $display("FAIL %s_timeout: got %0d words left want 0", nm, exp_q.size());
        end
        repeat (3) step();
    endtask

    task automatic wait_hs(input int target);
        int n;
        n = 0;
        while (hs_cnt < target && n < 200) begin
            step();
            n++;
        end
        checks++;
        if (hs_cnt < target) begin
            errors++;
            $display("FAIL hs_timeout: got %0d want %0d", hs_cnt, target);
        end
    endtask

    // Compare every output handshake against the model and enforce hold-while-stalled.
    always @(negedge SysClk) begin
        word_t e;
        if (!Rst_n) begin
            prev_v = 1'b0;
        end else begin
            if (prev_v && !prev_r && prev_cu) begin
                chk("hold_data", m_tdata, prev_d);
                chk("hold_ctl", 64'({m_tvalid, m_tlast, m_tkeep}), 64'({1'b1, prev_l, prev_k}));
            end
            if (trunc_pulse) trunc_seen++;
            if (m_tvalid && m_tready) begin
                hs_cnt++;
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_word: got %h want none", m_tdata);
                end else begin
                    e = exp_q.pop_front();
                    chk("tdata", m_tdata, e.d);
                    chk("tkeep", 64'(m_tkeep), 64'(e.k));
                    chk("tlast", 64'(m_tlast), 64'(e.l));
                    if (e.kind == 0) last_hdr = m_tdata;
                    if (e.kind == 2) last_trl = m_tdata;
                end
            end
            prev_v  = m_tvalid;
            prev_r  = m_tready;
            prev_cu = channel_up;
            prev_d  = m_tdata;
            prev_k  = m_tkeep;
            prev_l  = m_tlast;
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int base;
        repeat (3) step();
        chk("rst_tvalid", 64'(m_tvalid), 64'(0));
        chk("rst_tdata", m_tdata, 64'(0));
        chk("rst_tkeep_tlast", 64'({m_tkeep, m_tlast}), 64'(0));
        chk("rst_counters", 64'({frame_cnt, abort_cnt, trunc_pulse}), 64'(0));
        chk("rst_s_ready", 64'(s_ready), 64'(0));

        Rst_n = 1'b1;
        mk_a();
        send_pkt(mt);
        chk("model_trl_pin", mt, 64'hE7D3_0000_0004_3FFF);
        repeat (10) step();
        chk("chan_down_blocks", 64'({hs_cnt[7:0], m_tvalid}), 64'(0));
        channel_up = 1'b1;
        drain("pkt_a");
        chk("pkt_a_hdr", last_hdr, 64'hBC5A_0000_0000_0000);
        chk("pkt_a_trl", last_trl, 64'hE7D3_0000_0004_3FFF);
        chk("pkt_a_frames", 64'(frame_cnt), 64'(1));

        rmode = 1;
        mk_a();
        send_pkt(mt);
        drain("pkt_a_stall");
        chk("stall_hdr", last_hdr, 64'hBC5A_0001_0000_0000);
        chk("stall_trl", last_trl, 64'hE7D3_0000_0004_3FFF);
        chk("stall_frames", 64'(frame_cnt), 64'(2));

        rmode = 0;
        mk(7);
        send_pkt(mt);
        drain("trunc");
        chk("trunc_flags", 64'(last_trl[47:40]), 64'(8'h01));
        chk("trunc_wcnt", 64'(last_trl[31:16]), 64'(4));
        chk("trunc_pulses", 64'(trunc_seen), 64'(1));

        mk(4);
        send_pkt(mt);
        drain("exact_max");
        chk("exact_flags", 64'(last_trl[47:40]), 64'(0));
        chk("exact_pulses", 64'(trunc_seen), 64'(1));

        base = hs_cnt;
        mk(6);
        exp_q.push_back('{{16'hBC5A, m_seq, 32'h0}, 8'hFF, 1'b0, 0});
        exp_q.push_back('{pkt[0].d, pkt[0].k, 1'b0, 1});
        exp_q.push_back('{pkt[1].d, pkt[1].k, 1'b0, 1});
        foreach (pkt[i]) src_q.push_back(pkt[i]);
        m_aborts++;
        wait_hs(base + 3);
        channel_up = 1'b0;
        rmode = 3;
        m_tready = 1'b0;
        step();
        chk("abort_tvalid", 64'(m_tvalid), 64'(0));
        chk("abort_cnt", 64'(abort_cnt), 64'(1));
        channel_up = 1'b1;
        rmode = 0;
        drain("abort");
        chk("abort_frames", 64'(frame_cnt), 64'(m_frames));
        mk(3);
        send_pkt(mt);
        drain("post_abort");
        chk("post_abort_seq", 64'(last_hdr[47:32]), 64'(16'd4));

        gap = 1;
        rmode = 2;
        repeat (40) begin
            mk($urandom_range(1, 7));
            send_pkt(mt);
            drain("rand");
        end
        chk("rand_frames", 64'(frame_cnt), 64'(m_frames));
        chk("rand_aborts", 64'(abort_cnt), 64'(m_aborts));
        chk("rand_trunc", 64'(trunc_seen), 64'(m_trunc));

        gap = 0;
        rmode = 0;
        base = hs_cnt;
        mk(6);
        send_pkt(mt);
        wait_hs(base + 3);
        Rst_n = 1'b0;
        src_q.delete();
        exp_q.delete();
        s_valid = 1'b0;
        step();
        step();
        chk("mid_rst_tvalid", 64'(m_tvalid), 64'(0));
        chk("mid_rst_data", m_tdata, 64'(0));
        chk("mid_rst_counters", 64'({frame_cnt, abort_cnt, trunc_pulse, s_ready}), 64'(0));
        Rst_n = 1'b1;
        m_seq = '0;
        m_frames = 0;
        m_aborts = 0;
        mk_a();
        send_pkt(mt);
        drain("post_rst");
        chk("post_rst_hdr", last_hdr, 64'hBC5A_0000_0000_0000);
        chk("post_rst_frames", 64'(frame_cnt), 64'(1));

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
